// File: rtl/uart_pkg.sv
// Shared UART framing constants and state encoding for the rx/tx pair.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } state_t;

  // Clock cycles taken by one complete frame on the line.
  function automatic int frame_clks(input int cpb);
    return cpb * (1 + DATA_BITS + STOP_BITS);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial pin plus received-byte outputs; master is the line/consumer side, slave is the receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rxdata;
  logic                 rxfinish;
  logic                 frame_err;
  logic                 busy;

  modport master (output rx, input rxdata, input rxfinish, input frame_err, input busy);
  modport slave  (input rx, output rxdata, output rxfinish, output frame_err, output busy);

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous level input; 2-cycle latency, no backpressure.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, byte strobe at mid-stop-bit (HALF + 9 bit times after start edge).
// No backpressure: the consumer must take rxdata before the next frame completes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int HALF      = CLKS_PER_BIT / 2;
  localparam int CNT_WIDTH = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(HALF - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [2:0]           IDX_LAST = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rxdata;
  logic                 r_rxfinish;
  logic                 r_frame_err;
  logic                 w_bit_end;
  logic                 w_start_smp;
  logic                 w_good;
  logic                 w_bad;
  logic                 w_shift_en;
  logic                 w_busy;

  bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.rx),
    .o_sync  (w_rx_s)
  );

  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_start_smp = (r_cnt == CNT_HALF);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_WAIT_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_IDLE: if (w_rx_s && w_bit_end) w_state_nxt = S_IDLE;
      S_IDLE:      if (!w_rx_s) w_state_nxt = S_START;
      S_START:     if (w_start_smp) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (w_bit_end && (r_idx == IDX_LAST)) w_state_nxt = S_STOP;
      S_STOP:      if (w_bit_end) w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_IDLE;
      default:     w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_good     = (r_state == S_STOP) && w_bit_end && w_rx_s;
    w_bad      = (r_state == S_STOP) && w_bit_end && !w_rx_s;
    w_shift_en = (r_state == S_DATA) && w_bit_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_rxdata    <= '0;
      r_rxfinish  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rxfinish  <= w_good;
      r_frame_err <= w_bad;
      if (w_good) r_rxdata <= r_shift;

      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        r_idx   <= r_idx + 1'b1;
      end else if (r_state != S_DATA) begin
        r_idx <= '0;
      end

      // Every state change starts a fresh bit-time count.
      if (r_state != w_state_nxt) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          S_WAIT_IDLE: r_cnt <= w_rx_s ? r_cnt + 1'b1 : '0;
          S_START:     r_cnt <= r_cnt + 1'b1;
          S_DATA,
          S_STOP:      r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          default:     r_cnt <= '0;
        endcase
      end
    end
  end

  assign bus.rxdata    = r_rxdata;
  assign bus.rxfinish  = r_rxfinish;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued with their expected outcome and pulse cycle,
// a monitor pops and compares each rxfinish/frame_err pulse.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Pin-to-decision delay: two synchronizer flops, then the FSM edge that sees the low.
  localparam int EDGE_DLY = 3;
  localparam int PULSE_DLY = EDGE_DLY + HALF + 9 * CPB;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  logic [7:0] exp_rxdata;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp_v, exp_v, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one full frame starting at the current negedge and queues the expected outcome.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err  = !stop;
    e.data = d;
    e.cyc  = cyc + PULSE_DLY;
    exp_q.push_back(e);
    bus.rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_cyc(CPB);
    end
    bus.rx = stop;
    wait_cyc(CPB);
    bus.rx = 1'b1;
  endtask

  // Monitor: every pulse must match the head of the queue, in kind, cycle and data.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rxfinish && bus.frame_err) chk("mutex_pulses", 1, 0);
    if (bus.rxfinish || bus.frame_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (!e.err) exp_rxdata = e.data;
        chk("pulse_kind_rxfinish", int'(bus.rxfinish), int'(!e.err));
        chk("pulse_cycle", cyc, e.cyc);
        chk("rxdata_at_pulse", int'(bus.rxdata), int'(exp_rxdata));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n;
    logic [7:0] d;
    logic       bad;
    n_checks   = 0;
    n_errors   = 0;
    exp_rxdata = 8'h00;
    bus.rx     = 1'b1;
    reset      = 1'b1;
    wait_cyc(4);

    chk("reset_rxdata", int'(bus.rxdata), 0);
    chk("reset_rxfinish", int'(bus.rxfinish), 0);
    chk("reset_frame_err", int'(bus.frame_err), 0);
    chk("reset_busy", int'(bus.busy), 1);

    // Idle line after reset: IDLE reached after exactly CPB high samples.
    reset = 1'b0;
    r = cyc;
    wait_cyc(CPB - 1);
    chk("arm_busy_before", int'(bus.busy), 1);
    wait_cyc(1);
    chk("arm_busy_after", int'(bus.busy), 0);
    wait_cyc(4);

    // Single byte
    send_frame(8'hA5, 1'b1);
    chk("single_busy_done", int'(bus.busy), 0);
    chk("single_rxdata_held", int'(bus.rxdata), 8'hA5);
    wait_cyc(10);

    // Back-to-back, no gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(10);

    // Start glitch
    n = cyc;
    bus.rx = 1'b0;
    wait_cyc(5);
    bus.rx = 1'b1;
    wait_cyc(n + EDGE_DLY + HALF - 1 - cyc);
    chk("glitch_busy_start", int'(bus.busy), 1);
    wait_cyc(1);
    chk("glitch_busy_idle", int'(bus.busy), 0);
    wait_cyc(10);

    // Framing error after a good byte
    send_frame(8'hA5, 1'b1);
    wait_cyc(5);
    send_frame(8'h3C, 1'b0);
    r = cyc;
    chk("ferr_busy_low_line", int'(bus.busy), 1);
    chk("ferr_rxdata_kept", int'(bus.rxdata), 8'hA5);
    wait_cyc(EDGE_DLY + CPB - 2);
    chk("ferr_busy_rearm_before", int'(bus.busy), 1);
    wait_cyc(1);
    chk("ferr_busy_rearm_after", int'(bus.busy), 0);
    wait_cyc(5);

    // Reset during data bit 3, released while the line is low
    bus.rx = 1'b0;
    wait_cyc(CPB + 3 * CPB + 5);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    chk("rst_mid_busy", int'(bus.busy), 1);
    wait_cyc(10);
    bus.rx = 1'b1;
    wait_cyc(EDGE_DLY + CPB - 2);
    chk("rst_mid_busy_before", int'(bus.busy), 1);
    wait_cyc(1);
    chk("rst_mid_busy_after", int'(bus.busy), 0);
    wait_cyc(3);
    send_frame(8'h5A, 1'b1);
    wait_cyc(10);

    // Randomized frames: mostly good, occasional bad stop bit, random idle gaps
    for (int k = 0; k < 30; k++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(d, !bad);
      if (bad) wait_cyc($urandom_range(CPB + 4, 2 * CPB + 8));
      else     wait_cyc($urandom_range(0, 20));
    end

    wait_cyc(20);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
